// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic device among NUM_CTRL controllers.
// Latency: grant 1 clock after c_cyc_i in IDLE; device responses routed back in 0 clocks.
// Backpressure: waiters stall until the owner drops c_cyc_i; optional watchdog (WB_ARB_WATCHDOG_EN) errors stalled strobes.
module wishbone_classic_arbiter #(
    parameter int NUM_CTRL  = 4,
    parameter int DAT_WIDTH = 8,
    parameter int ADR_WIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CTRL-1:0]           c_cyc_i,
    input  logic [NUM_CTRL-1:0]           c_stb_i,
    input  logic [NUM_CTRL-1:0]           c_we_i,
    input  logic [NUM_CTRL*ADR_WIDTH-1:0] c_adr_i,
    input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
    output logic [NUM_CTRL-1:0]           c_ack_o,
    output logic [NUM_CTRL-1:0]           c_err_o,
    output logic [NUM_CTRL-1:0]           c_rty_o,
    output logic [DAT_WIDTH-1:0]          c_dat_o,
    output logic                          d_cyc_o,
    output logic                          d_stb_o,
    output logic                          d_we_o,
    output logic [ADR_WIDTH-1:0]          d_adr_o,
    output logic [DAT_WIDTH-1:0]          d_dat_o,
    input  logic                          d_ack_i,
    input  logic                          d_err_i,
    input  logic                          d_rty_i,
    input  logic [DAT_WIDTH-1:0]          d_dat_i,
    output logic [NUM_CTRL-1:0]           grant_o
);

    localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CTRL - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CTRL-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;

    logic                 owner_cyc;
    logic                 owner_stb;
    logic                 owner_we;
    logic [ADR_WIDTH-1:0] owner_adr;
    logic [DAT_WIDTH-1:0] owner_dat;

    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 arb_en;

    logic                 wd_limit;
    logic                 wd_err;

    assign owner_cyc = |(grant_q & c_cyc_i);
    assign owner_stb = |(grant_q & c_stb_i);
    assign owner_we  = |(grant_q & c_we_i);

    // Select the owner's address and write data through the one-hot grant
    always_comb begin
        owner_adr = '0;
        owner_dat = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (grant_q[k]) begin
                owner_adr = owner_adr | c_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
                owner_dat = owner_dat | c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    // Round-robin search: first requester after last_q, wrapping; last_q itself is checked last
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = '0;
        for (int i = 1; i <= NUM_CTRL; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_CTRL);
            if (!win_vld && c_cyc_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state: re-arbitrate only when idle or when the owner has released its cycle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        arb_en  = (state_q == ST_IDLE) || !owner_cyc;
        if (arb_en) begin
            grant_d = '0;
            if (win_vld) begin
                grant_d[win_idx] = 1'b1;
                last_d           = win_idx;
                state_d          = ST_OWNED;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Ownership registers; reset gives controller 0 first priority
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        dev_rsp;

    assign dev_rsp  = d_ack_i | d_err_i | d_rty_i;
    // The limit clock forces the strobe low without looking at the response, so a
    // combinational-ack device cannot form a loop through d_stb_o.
    assign wd_limit = (wd_cnt_q == 16'(TIMEOUT));
    // A response landing in the limit clock takes precedence over the injected error
    assign wd_err   = wd_limit & ~dev_rsp;

    // Count stalled strobe clocks; any response, ownership change or idle strobe restarts it
    always_comb begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        if (wd_limit || dev_rsp || !(d_cyc_o && d_stb_o) || (grant_d != grant_q)) begin
            wd_cnt_d = '0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    // Without the watchdog the arbiter waits forever; TIMEOUT is legal from 2 up, so this is 0
    assign wd_limit = (TIMEOUT == 0);
    assign wd_err   = 1'b0;
`endif

    assign d_cyc_o = owner_cyc;
    assign d_stb_o = owner_stb & ~wd_limit;
    assign d_we_o  = owner_we;
    assign d_adr_o = owner_adr;
    assign d_dat_o = owner_dat;

    assign c_ack_o = grant_q & {NUM_CTRL{d_ack_i}};
    assign c_err_o = grant_q & {NUM_CTRL{d_err_i | wd_err}};
    assign c_rty_o = grant_q & {NUM_CTRL{d_rty_i}};
    assign c_dat_o = d_dat_i;

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// Bench for wishbone_classic_arbiter: table of per-clock vectors through a scoreboard queue,
// plus hand sequences for stalled strobes (watchdog expiry when WB_ARB_WATCHDOG_EN is defined).
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_wishbone_classic_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  c_cyc_i, c_stb_i, c_we_i;
    logic [31:0] c_adr_i, c_dat_i;
    logic [3:0]  c_ack_o, c_err_o, c_rty_o;
    logic [7:0]  c_dat_o;
    logic        d_cyc_o, d_stb_o, d_we_o;
    logic [7:0]  d_adr_o, d_dat_o;
    logic        d_ack_i, d_err_i, d_rty_i;
    logic [7:0]  d_dat_i;
    logic [3:0]  grant_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wishbone_classic_arbiter #(
        .NUM_CTRL (4),
        .DAT_WIDTH(8),
        .ADR_WIDTH(8),
        .TIMEOUT  (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .c_cyc_i(c_cyc_i),
        .c_stb_i(c_stb_i),
        .c_we_i (c_we_i),
        .c_adr_i(c_adr_i),
        .c_dat_i(c_dat_i),
        .c_ack_o(c_ack_o),
        .c_err_o(c_err_o),
        .c_rty_o(c_rty_o),
        .c_dat_o(c_dat_o),
        .d_cyc_o(d_cyc_o),
        .d_stb_o(d_stb_o),
        .d_we_o (d_we_o),
        .d_adr_o(d_adr_o),
        .d_dat_o(d_dat_o),
        .d_ack_i(d_ack_i),
        .d_err_i(d_err_i),
        .d_rty_i(d_rty_i),
        .d_dat_i(d_dat_i),
        .grant_o(grant_o)
    );

    // One clock of stimulus and the outputs required while it is held
    typedef struct {
        logic       rst;
        logic [3:0] cyc, stb, we;
        logic       ack, err, rty;
        logic [3:0] grant, ack_o, err_o, rty_o;
    } vec_t;

    typedef struct {
        logic [3:0]  grant;
        logic [18:0] dev;
        logic [11:0] rsp;
        logic [7:0]  cdat;
    } exp_t;

    vec_t rows[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                                input logic [3:0] we, input logic ack, input logic err,
                                input logic rty, input logic [3:0] grant, input logic [3:0] ack_o,
                                input logic [3:0] err_o, input logic [3:0] rty_o);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we;
        v.ack = ack; v.err = err; v.rty = rty;
        v.grant = grant; v.ack_o = ack_o; v.err_o = err_o; v.rty_o = rty_o;
        return v;
    endfunction

    // Device-side view expected from the owner named in the vector's expected grant
    function automatic exp_t model(input vec_t v, input logic [7:0] ddat);
        exp_t e;
        e.grant = v.grant;
        e.dev   = '0;
        for (int k = 0; k < 4; k++) begin
            if (v.grant[k]) begin
                e.dev = {v.cyc[k], v.stb[k], v.we[k], 8'(8'hA0 + k), 8'(8'h50 + k)};
            end
        end
        e.rsp  = {v.ack_o, v.err_o, v.rty_o};
        e.cdat = ddat;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic ack);
        @(posedge clk_i);
        #1;
        c_cyc_i = cyc;
        c_stb_i = stb;
        d_ack_i = ack;
        @(negedge clk_i);
    endtask

    initial begin
        // fields: rst cyc stb we ack err rty | grant ack_o err_o rty_o
        // controllers 0 and 2 collide after reset
        rows.push_back(mk(0, 4'b0101, 4'b0101, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0101, 4'b0101, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // reset restores controller 0 priority, then all four rotate 0,1,2,3,0
        rows.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1110, 4'b1110, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1110, 4'b1110, 4'b0000, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1101, 4'b1101, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1101, 4'b1101, 4'b0000, 1, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1011, 4'b1011, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1011, 4'b1011, 4'b0000, 1, 0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0111, 4'b0111, 4'b0000, 0, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0111, 4'b0111, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // controller 1 holds the bus for 3 acked writes while 3 waits
        rows.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1010, 4'b1010, 4'b1010, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1010, 4'b1010, 4'b1010, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1010, 4'b1010, 4'b1010, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // err then rty then ack to owner 2
        rows.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000));
        rows.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100));
        rows.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // reset in the middle of controller 1's cycle, then controller 0 wins first
        rows.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0011, 4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0011, 4'b0011, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
        rows.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));

        // requests held during reset must not produce a grant
        rst_i   = 1'b0;
        c_cyc_i = 4'b1111;
        c_stb_i = 4'b1111;
        c_we_i  = 4'b1111;
        c_adr_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        c_dat_i = {8'h53, 8'h52, 8'h51, 8'h50};
        d_ack_i = 1'b1;
        d_err_i = 1'b0;
        d_rty_i = 1'b0;
        d_dat_i = 8'h00;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset grant", 32'(grant_o), 32'h0);
        chk("reset dev", 32'({d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o}), 32'h0);
        chk("reset rsp", 32'({c_ack_o, c_err_o, c_rty_o}), 32'h0);

        for (int i = 0; i < rows.size(); i++) begin
            logic [7:0] dd;
            exp_t       e;
            dd = 8'(8'h30 + i);
            @(posedge clk_i);
            #1;
            rst_i   = ~rows[i].rst;
            c_cyc_i = rows[i].cyc;
            c_stb_i = rows[i].stb;
            c_we_i  = rows[i].we;
            d_ack_i = rows[i].ack;
            d_err_i = rows[i].err;
            d_rty_i = rows[i].rty;
            d_dat_i = dd;
            sb.push_back(model(rows[i], dd));
            @(negedge clk_i);
            e = sb.pop_front();
            chk($sformatf("row%0d grant", i), 32'(grant_o), 32'(e.grant));
            chk($sformatf("row%0d dev", i),
                32'({d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o}), 32'(e.dev));
            chk($sformatf("row%0d rsp", i), 32'({c_ack_o, c_err_o, c_rty_o}), 32'(e.rsp));
            chk($sformatf("row%0d cdat", i), 32'(c_dat_o), 32'(e.cdat));
        end

`ifdef WB_ARB_WATCHDOG_EN
        // device never answers: error and dropped strobe exactly 4 clocks after strobe begins
        drive(4'b0001, 4'b0001, 1'b0);
        chk("wd pre grant", 32'(grant_o), 32'h0);
        for (int j = 0; j < 6; j++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            chk($sformatf("wd stb j%0d", j), 32'(d_stb_o), (j == 4) ? 32'h0 : 32'h1);
            chk($sformatf("wd err j%0d", j), 32'(c_err_o), (j == 4) ? 32'h1 : 32'h0);
        end
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        // ack landing in the limit clock passes through with no injected error
        drive(4'b0001, 4'b0001, 1'b0);
        for (int j = 0; j < 5; j++) begin
            drive(4'b0001, 4'b0001, (j == 4));
            chk($sformatf("wd2 ack j%0d", j), 32'(c_ack_o), (j == 4) ? 32'h1 : 32'h0);
            chk($sformatf("wd2 err j%0d", j), 32'(c_err_o), 32'h0);
        end
        drive(4'b0000, 4'b0000, 1'b0);
`else
        // without the watchdog a silent device leaves the strobe up indefinitely
        drive(4'b0100, 4'b0100, 1'b0);
        for (int j = 0; j < 20; j++) begin
            drive(4'b0100, 4'b0100, 1'b0);
            chk($sformatf("stall stb j%0d", j), 32'({grant_o, d_stb_o}), 32'({4'b0100, 1'b1}));
            chk($sformatf("stall err j%0d", j), 32'(c_err_o), 32'h0);
        end
        drive(4'b0000, 4'b0000, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
